serial_add_ctrl: RTL and testbench
==================================

SERIAL_ADD_CTRL -- requirements
Module: serial_add_ctrl

Interface
REQ-001 Parameter: WIDTH, default 16, operand width in bits; SHALL be even and >= 2; STEPS = WIDTH/2.
REQ-002 clk  input  1  single clock, all state updates on rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 in_valid  input  1  operand request valid.
REQ-005 in_ready  output  1  controller idle, can accept a request.
REQ-006 a  input  WIDTH  operand A, unsigned or two's complement.
REQ-007 b  input  WIDTH  operand B.
REQ-008 cin  input  1  carry-in (add) / borrow-in (sub).
REQ-009 sub  input  1  0 = a+b+cin; 1 = a-b-cin.
REQ-010 out_valid  output  1  result valid.
REQ-011 out_ready  input  1  consumer accepts result.
REQ-012 sum  output  WIDTH  result.
REQ-013 cout  output  1  final carry-out (sub: 1 = no borrow).
REQ-014 ovf  output  1  signed overflow.
REQ-015 busy  output  1  high in RUN and DONE.

Function
REQ-016 Datapath SHALL be one 2-bit full-adder slice (A[1:0]+B[1:0]+Cin -> 2-bit sum, carry-out), reused over STEPS cycles; no WIDTH-wide adder.
REQ-017 FSM states SHALL be IDLE, RUN, DONE.
REQ-018 IDLE: in_ready=1, out_valid=0; on in_valid=1 at an edge -> latch a, b_eff = sub ? ~b : b, carry = sub ? ~cin : cin, step=0, go RUN.
REQ-019 RUN: each edge SHALL add bits [2k+1:2k] of latched a and b_eff with carry register, write 2 sum bits to position k, update carry, k+1; after step STEPS-1, go DONE.
REQ-020 Operand inputs and in_valid SHALL be ignored outside IDLE; in_ready=0 in RUN and DONE.
REQ-021 Latency: out_valid SHALL first be 1 exactly STEPS edges after the accept edge (8 for WIDTH=16).
REQ-022 DONE: out_valid=1; sum, cout, ovf stable until out_ready=1 sampled; then go IDLE.
REQ-023 No same-edge result-accept and new-request accept: minimum throughput one operation per STEPS+2 cycles.
REQ-024 cout SHALL equal carry out of final step; ovf = (a[WIDTH-1]==b_eff[WIDTH-1]) && (sum[WIDTH-1]!=a[WIDTH-1]).
REQ-025 sum, cout, ovf SHALL be zero while out_valid=0 at any time before the first result; after DONE->IDLE, they SHALL hold last result (out_valid=0).
REQ-026 Results SHALL equal (a + b_eff + carry_init) mod 2^WIDTH for every input including all-ones and zero operands.

Reset
REQ-027 rst_n=0 SHALL immediately force IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0, step=0, carry=0.
REQ-028 Reset asserted in RUN or DONE SHALL abort the operation; no result SHALL appear after release.
REQ-029 First accept possible on first rising edge with rst_n=1 and in_valid=1.

Verification (WIDTH=16)
REQ-030 a=0x1234, b=0x4321, cin=0, sub=0 -> sum=0x5555, cout=0, ovf=0, out_valid 8 edges after accept.
REQ-031 a=0xFFFF, b=0x0000, cin=1, sub=0 -> sum=0x0000, cout=1, ovf=0 (carry ripples through all 8 steps).
REQ-032 a=0x7FFF, b=0x0001, cin=0, sub=0 -> sum=0x8000, cout=0, ovf=1; a=0x0005, b=0x0007, cin=0, sub=1 -> sum=0xFFFE, cout=0, ovf=0.
REQ-033 Backpressure: out_ready=0 for 5 cycles in DONE with in_valid=1 and changing a/b -> sum/out_valid held, no new accept; out_ready=1 -> IDLE next edge, in_ready=1.
REQ-034 Reset pulse during RUN at step 3 -> all outputs 0 asynchronously, in_ready=1 after release, no out_valid until a new request completes.
REQ-035 Random back-to-back requests (>=1000) with random out_ready -> every result matches reference model in REQ-026.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl
//   Multi-cycle adder/subtractor. It uses one 2-bit full-adder slice over
//   WIDTH/2 cycles and returns the result with a valid/ready handshake.
//   In subtract mode B and the carry-in are inverted, which gives
//   a - b - cin in two's complement. In that mode cout=1 means no borrow.
//
// Parameters
//   WIDTH      operand width in bits, must be even and >= 2
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   request valid (sampled only while idle)
//   in_ready   controller idle, request is accepted on the next edge
//   a, b       operands
//   cin        carry-in (add) / borrow-in (sub)
//   sub        0: a+b+cin, 1: a-b-cin
//   out_valid  result valid, held until out_ready is sampled high
//   out_ready  consumer accepts result
//   sum        result (zero until the first result; then holds the last result)
//   cout       carry out of the final step
//   ovf        signed overflow
//   busy       operation in progress or result pending
module serial_add_ctrl #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned STEPS = WIDTH / 2;
  localparam int unsigned SW    = (STEPS > 1) ? $clog2(STEPS) : 1;
  localparam logic [SW-1:0] LAST_STEP = SW'(STEPS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic             carry_q, carry_d;
  logic [SW-1:0]    step_q, step_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             cout_q, cout_d;
  logic             ovf_q, ovf_d;

  logic [2:0]       slice;
  logic [WIDTH+1:0] acc_shift;

  // The operand registers shift right by two bits each step. The slice
  // always reads bits [1:0], and the sum bits enter acc from the top. After
  // STEPS steps every pair of sum bits has reached position k. On the last
  // step, a_q[1] and b_q[1] are the original sign bits, and ovf uses them.
  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    carry_d   = carry_q;
    step_d    = step_q;
    acc_d     = acc_q;
    sum_d     = sum_q;
    cout_d    = cout_q;
    ovf_d     = ovf_q;

    slice     = {1'b0, a_q[1:0]} + {1'b0, b_q[1:0]} + {2'b00, carry_q};
    acc_shift = {slice[1:0], acc_q};

    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_d     = a;
          b_d     = sub ? ~b : b;
          carry_d = sub ? ~cin : cin;
          step_d  = '0;
          acc_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        a_d     = a_q >> 2;
        b_d     = b_q >> 2;
        carry_d = slice[2];
        acc_d   = acc_shift[WIDTH+1:2];
        step_d  = step_q + SW'(1);
        if (step_q == LAST_STEP) begin
          sum_d   = acc_shift[WIDTH+1:2];
          cout_d  = slice[2];
          ovf_d   = (a_q[1] == b_q[1]) && (slice[1] != a_q[1]);
          step_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      carry_q <= 1'b0;
      step_q  <= '0;
      acc_q   <= '0;
      sum_q   <= '0;
      cout_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      carry_q <= carry_d;
      step_q  <= step_d;
      acc_q   <= acc_d;
      sum_q   <= sum_d;
      cout_q  <= cout_d;
      ovf_q   <= ovf_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign sum       = sum_q;
  assign cout      = cout_q;
  assign ovf       = ovf_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// tb_serial_add_ctrl
//   Directed and random checks of serial_add_ctrl with WIDTH=16. Inputs are
//   driven and outputs are sampled on the falling clock edge.
module tb_serial_add_ctrl;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [15:0] a = '0;
  logic [15:0] b = '0;
  logic        cin = 1'b0;
  logic        sub = 1'b0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [15:0] sum;
  logic        cout;
  logic        ovf;
  logic        busy;

  int total = 0;
  int bad   = 0;

  serial_add_ctrl #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .sub       (sub),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .ovf       (ovf),
    .busy      (busy)
  );

  initial forever #5 clk = ~clk;

  initial begin
    #5000000;
    $display("FAIL watchdog: observed=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // This task must be called at a falling edge. It presents the request,
  // lets it be accepted, and returns at the next falling edge.
  task automatic start_op(input logic [15:0] ta, input logic [15:0] tb_v,
                          input logic tc, input logic ts);
    chk("in_ready_pre", 32'(in_ready), 32'd1);
    a = ta; b = tb_v; cin = tc; sub = ts; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_done(output int lat);
    lat = 0;
    while (!out_valid && lat < 40) begin
      @(posedge clk);
      @(negedge clk);
      lat++;
    end
    chk("result_valid", 32'(out_valid), 32'd1);
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_dir(input string tag, input logic [15:0] ta, input logic [15:0] tb_v,
                         input logic tc, input logic ts, input logic [15:0] es,
                         input logic ec, input logic eo, input logic zero_in_run);
    int lat;
    start_op(ta, tb_v, tc, ts);
    chk({tag, "_busy"}, 32'(busy), 32'd1);
    chk({tag, "_in_ready_run"}, 32'(in_ready), 32'd0);
    if (zero_in_run) chk({tag, "_sum_zero_run"}, 32'(sum), 32'd0);
    wait_done(lat);
    chk({tag, "_latency"}, 32'(lat), 32'd8);
    chk({tag, "_sum"}, 32'(sum), 32'(es));
    chk({tag, "_cout"}, 32'(cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(ovf), 32'(eo));
    release_result();
    chk({tag, "_in_ready_post"}, 32'(in_ready), 32'd1);
    chk({tag, "_out_valid_post"}, 32'(out_valid), 32'd0);
    chk({tag, "_sum_hold"}, 32'(sum), 32'(es));
  endtask

  initial begin
    int lat;
    logic [15:0] ra, rb, beff;
    logic        rc, rs, ci, eo;
    logic [16:0] full;
    int          tries;

    // Reset state
    #3;
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_res", 32'({cout, ovf, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Directed vectors
    run_dir("add1", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0, 1'b1);
    run_dir("ripple", 16'hFFFF, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_dir("ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0);
    run_dir("sub", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    run_dir("sub_eq", 16'h8000, 16'h8000, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b0);
    run_dir("allones", 16'hFFFF, 16'hFFFF, 1'b1, 1'b0, 16'hFFFF, 1'b1, 1'b0, 1'b0);

    // Backpressure: the result must hold and new requests must be ignored
    start_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    wait_done(lat);
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      a = 16'(i * 16'h0101 + 16'h00A0);
      b = 16'(i * 16'h1010 + 16'h0B00);
      @(posedge clk);
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_sum", 32'(sum), 32'h3333);
    end
    out_ready = 1'b1;
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    chk("bp_in_ready_post", 32'(in_ready), 32'd1);
    chk("bp_out_valid_post", 32'(out_valid), 32'd0);
    chk("bp_sum_post", 32'(sum), 32'h3333);
    in_valid = 1'b0;
    @(negedge clk);

    // Reset pulse during RUN (the reset arrives at step 3)
    start_op(16'h00FF, 16'h0F0F, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("rrun_in_ready", 32'(in_ready), 32'd1);
    chk("rrun_out_valid", 32'(out_valid), 32'd0);
    chk("rrun_busy", 32'(busy), 32'd0);
    chk("rrun_res", 32'({cout, ovf, sum}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      @(negedge clk);
      chk("rrun_no_result", 32'(out_valid), 32'd0);
    end
    run_dir("post_rst", 16'h8001, 16'h8001, 1'b0, 1'b0, 16'h0002, 1'b1, 1'b1, 1'b1);

    // Random back-to-back requests with random out_ready
    for (int n = 0; n < 1000; n++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      if (n % 10 == 0) ra = 16'hFFFF;
      if (n % 13 == 0) rb = 16'h0000;
      rc = 1'($urandom_range(0, 1));
      rs = 1'($urandom_range(0, 1));
      beff = rs ? ~rb : rb;
      ci   = rs ? ~rc : rc;
      full = {1'b0, ra} + {1'b0, beff} + {16'd0, ci};
      eo   = (ra[15] == beff[15]) && (full[15] != ra[15]);
      start_op(ra, rb, rc, rs);
      wait_done(lat);
      chk("rnd_result", 32'({full[16], eo, full[15:0]}), 32'({cout, ovf, sum}) ^ 32'd0);
      tries = 0;
      do begin
        out_ready = (tries >= 8) ? 1'b1 : 1'($urandom_range(0, 1));
        @(posedge clk);
        @(negedge clk);
        tries++;
      end while (!out_ready);
      out_ready = 1'b0;
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
